prog_adr_dec: RTL

PROG_ADR_DEC -- requirements
Module: prog_adr_dec

---
 rtl/prog_adr_dec_if.sv | 47 ++++
 rtl/prog_adr_dec.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/prog_adr_dec_if.sv
// Request/response, region-config and fault-capture signals of prog_adr_dec.
// master = requester/configurer, slave = decoder.
interface prog_adr_dec_if #(
   parameter int PA_BITS  = 34,
   parameter int NREGIONS = 8
);
   localparam int IW = $clog2(NREGIONS);

   logic                CfgWrEn;
   logic [IW-1:0]       CfgIdx;
   logic [PA_BITS-1:0]  CfgBase;
   logic [PA_BITS-1:0]  CfgRange;
   logic [2:0]          CfgPerm;
   logic [3:0]          CfgSizes;
   logic                CfgEnable;

   logic                ReqValid;
   logic                ReqReady;
   logic [PA_BITS-1:0]  PhysicalAddress;
   logic [1:0]          Size;
   logic                AccessR;
   logic                AccessW;
   logic                AccessX;

   logic                RespValid;
   logic                RespReady;
   logic [NREGIONS:0]   SelRegions;
   logic                RespFault;

   logic                FaultValid;
   logic [PA_BITS-1:0]  FaultAddress;
   logic                FaultClear;

   modport master (
      output CfgWrEn, CfgIdx, CfgBase, CfgRange, CfgPerm, CfgSizes, CfgEnable,
      output ReqValid, PhysicalAddress, Size, AccessR, AccessW, AccessX,
      output RespReady, FaultClear,
      input  ReqReady, RespValid, SelRegions, RespFault, FaultValid, FaultAddress
   );

   modport slave (
      input  CfgWrEn, CfgIdx, CfgBase, CfgRange, CfgPerm, CfgSizes, CfgEnable,
      input  ReqValid, PhysicalAddress, Size, AccessR, AccessW, AccessX,
      input  RespReady, FaultClear,
      output ReqReady, RespValid, SelRegions, RespFault, FaultValid, FaultAddress
   );
endinterface

// File: rtl/prog_adr_dec.sv
// Programmable address decoder: NREGIONS base/mask windows, lowest-index priority, 1-cycle latency.
// Optional fault-address capture enabled by `define PROG_ADR_DEC_FAULT_CAPTURE_EN.
module prog_adr_dec_region #(
   parameter int PA_BITS = 34
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [PA_BITS-1:0] cfg_base,
   input  logic [PA_BITS-1:0] cfg_range,
   input  logic [2:0]         cfg_perm,
   input  logic [3:0]         cfg_sizes,
   input  logic               cfg_enable,
   input  logic [PA_BITS-1:0] addr,
   input  logic [1:0]         size,
   input  logic [2:0]         access,
   output logic               hit
);
   typedef struct packed {
      logic               enable;
      logic [PA_BITS-1:0] base;
      logic [PA_BITS-1:0] range;
      logic [2:0]         perm;
      logic [3:0]         sizes;
   } entry_t;

   entry_t ent_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ent_q <= '0;
      end else if (wr_en) begin
         ent_q.enable <= cfg_enable;
         ent_q.base   <= cfg_base;
         ent_q.range  <= cfg_range;
         ent_q.perm   <= cfg_perm;
         ent_q.sizes  <= cfg_sizes;
      end
   end

   // Pure bitwise mask compare: no carries, all-ones range matches anything.
   assign hit = ent_q.enable
              && ((addr & ~ent_q.range) == (ent_q.base & ~ent_q.range))
              && ent_q.sizes[size]
              && ((access & ~ent_q.perm) == 3'b000);
endmodule

module prog_adr_dec #(
   parameter int PA_BITS  = 34,
   parameter int NREGIONS = 8
) (
   input  logic             clk,
   input  logic             reset,
   prog_adr_dec_if.slave    bus
);
   localparam int IW = $clog2(NREGIONS);

   logic [NREGIONS-1:0] hit;
   logic [NREGIONS:0]   sel_d;
   logic [NREGIONS:0]   sel_q;
   logic                found;
   logic                resp_valid_q;
   logic                fault_q;
   logic                req_ready;
   logic                accept;

   // Writes with CfgIdx >= NREGIONS match no instance and are dropped.
   for (genvar i = 0; i < NREGIONS; i++) begin : g_region
      prog_adr_dec_region #(.PA_BITS(PA_BITS)) u_region (
         .clk        (clk),
         .reset      (reset),
         .wr_en      (bus.CfgWrEn && (bus.CfgIdx == IW'(i))),
         .cfg_base   (bus.CfgBase),
         .cfg_range  (bus.CfgRange),
         .cfg_perm   (bus.CfgPerm),
         .cfg_sizes  (bus.CfgSizes),
         .cfg_enable (bus.CfgEnable),
         .addr       (bus.PhysicalAddress),
         .size       (bus.Size),
         .access     ({bus.AccessX, bus.AccessW, bus.AccessR}),
         .hit        (hit[i])
      );
   end

   always_comb begin
      sel_d = '0;
      found = 1'b0;
      for (int i = 0; i < NREGIONS; i++) begin
         if (hit[i] && !found) begin
            sel_d[i+1] = 1'b1;
            found      = 1'b1;
         end
      end
      sel_d[0] = ~found;
   end

   assign req_ready = ~resp_valid_q | bus.RespReady;
   assign accept    = bus.ReqValid & req_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_valid_q <= 1'b0;
         sel_q        <= (NREGIONS+1)'(1);
         fault_q      <= 1'b0;
      end else if (accept) begin
         resp_valid_q <= 1'b1;
         sel_q        <= sel_d;
         fault_q      <= ~found;
      end else if (bus.RespReady) begin
         resp_valid_q <= 1'b0;
      end
   end

   assign bus.ReqReady   = req_ready;
   assign bus.RespValid  = resp_valid_q;
   assign bus.SelRegions = sel_q;
   assign bus.RespFault  = fault_q;

`ifdef PROG_ADR_DEC_FAULT_CAPTURE_EN
   logic               fault_valid_q;
   logic [PA_BITS-1:0] fault_addr_q;

   // A clear in the same cycle as a new fault re-arms and captures at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault_valid_q <= 1'b0;
         fault_addr_q  <= '0;
      end else if (accept && !found && (!fault_valid_q || bus.FaultClear)) begin
         fault_valid_q <= 1'b1;
         fault_addr_q  <= bus.PhysicalAddress;
      end else if (bus.FaultClear) begin
         fault_valid_q <= 1'b0;
      end
   end

   assign bus.FaultValid   = fault_valid_q;
   assign bus.FaultAddress = fault_addr_q;
`else
   logic unused_fault_clear;
   assign unused_fault_clear = bus.FaultClear;
   assign bus.FaultValid     = 1'b0;
   assign bus.FaultAddress   = '0;
`endif
endmodule
